// File: rtl/write_back_if.sv
// Execute-to-write-back handshake plus the data-memory store port.
// The master side is the environment (execute stage and memory), the slave side is write_back.
interface write_back_if;
    logic        in_valid;
    logic        in_hold;
    logic [31:0] in_pc;
    logic [4:0]  in_target_register;
    logic [4:0]  in_address_register;
    logic        in_is_writing_memory;
    logic [3:0]  in_flags;
    logic [31:0] in_target_value;
    logic [31:0] in_upper_value;
    logic [31:0] in_adjustment_value;
    logic        in_has_upper_value;
    logic        in_has_flushed;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_write;
    logic        mem_waitrequest;

    modport master (
        output in_valid, in_pc, in_target_register, in_address_register,
        output in_is_writing_memory, in_flags, in_target_value, in_upper_value,
        output in_adjustment_value, in_has_upper_value, in_has_flushed,
        output mem_waitrequest,
        input  in_hold, mem_address, mem_writedata, mem_write
    );

    modport slave (
        input  in_valid, in_pc, in_target_register, in_address_register,
        input  in_is_writing_memory, in_flags, in_target_value, in_upper_value,
        input  in_adjustment_value, in_has_upper_value, in_has_flushed,
        input  mem_waitrequest,
        output in_hold, mem_address, mem_writedata, mem_write
    );
endinterface

// File: rtl/write_back.sv
// Final pipeline stage: architectural register file, instruction retirement,
// wait-request data-memory stores and a same-cycle forwarding channel.
module write_back #(
    parameter int FLAGS_INDEX = 30
) (
    input  logic          clock,
    input  logic          reset,
    write_back_if.slave   bus,
    output logic [1023:0] registers,
    output logic          fb_is_valid,
    output logic [4:0]    fb_index,
    output logic [31:0]   fb_value,
    output logic          retired,
    output logic [31:0]   retired_pc
);

    localparam logic [4:0] FLAGS_IDX = 5'(FLAGS_INDEX);

    typedef enum logic [1:0] {
        READY,
        UPPER,
        STORE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] upper_value_q, upper_value_d;
    logic [4:0]  upper_index_q, upper_index_d;
    logic        pending_upper_q, pending_upper_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic        mem_write_q, mem_write_d;
    logic        retired_q, retired_d;
    logic [31:0] retired_pc_q, retired_pc_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= READY;
            for (int n = 0; n < 32; n++) regs_q[n] <= '0;
            upper_value_q   <= '0;
            upper_index_q   <= '0;
            pending_upper_q <= 1'b0;
            pc_q            <= '0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            mem_write_q     <= 1'b0;
            retired_q       <= 1'b0;
            retired_pc_q    <= '0;
        end else begin
            state_q         <= state_d;
            regs_q          <= regs_d;
            upper_value_q   <= upper_value_d;
            upper_index_q   <= upper_index_d;
            pending_upper_q <= pending_upper_d;
            pc_q            <= pc_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            mem_write_q     <= mem_write_d;
            retired_q       <= retired_d;
            retired_pc_q    <= retired_pc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        regs_d          = regs_q;
        upper_value_d   = upper_value_q;
        upper_index_d   = upper_index_q;
        pending_upper_d = pending_upper_q;
        pc_d            = pc_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        mem_write_d     = mem_write_q;
        retired_d       = 1'b0;
        retired_pc_d    = retired_pc_q;
        fb_is_valid     = 1'b0;
        fb_index        = bus.in_target_register;
        fb_value        = bus.in_target_value;

        unique case (state_q)
            READY: begin
                fb_is_valid = bus.in_valid & ~bus.in_has_flushed & ~bus.in_is_writing_memory;
                if (bus.in_valid && !bus.in_has_flushed) begin
                    pc_d            = bus.in_pc;
                    upper_value_d   = bus.in_upper_value;
                    upper_index_d   = bus.in_target_register + 5'd1;
                    pending_upper_d = bus.in_has_upper_value;
                    regs_d[FLAGS_IDX][30:27] = bus.in_flags;
                    if (bus.in_is_writing_memory) begin
                        // Address comes from the pre-edge register file, never the bypass.
                        mem_address_d   = regs_q[bus.in_address_register] + bus.in_adjustment_value;
                        mem_writedata_d = bus.in_target_value;
                        mem_write_d     = 1'b1;
                        state_d         = STORE;
                    end else begin
                        // Ordered after the flags merge so a direct write to the flags register wins.
                        regs_d[bus.in_target_register] = bus.in_target_value;
                        if (bus.in_has_upper_value) begin
                            state_d = UPPER;
                        end else begin
                            retired_d    = 1'b1;
                            retired_pc_d = bus.in_pc;
                        end
                    end
                end
            end
            UPPER: begin
                fb_is_valid           = 1'b1;
                fb_index              = upper_index_q;
                fb_value              = upper_value_q;
                regs_d[upper_index_q] = upper_value_q;
                pending_upper_d       = 1'b0;
                state_d               = READY;
                retired_d             = 1'b1;
                retired_pc_d          = pc_q;
            end
            STORE: begin
                if (!bus.mem_waitrequest) begin
                    mem_write_d = 1'b0;
                    if (pending_upper_q) begin
                        state_d = UPPER;
                    end else begin
                        state_d      = READY;
                        retired_d    = 1'b1;
                        retired_pc_d = pc_q;
                    end
                end
            end
            default: state_d = READY;
        endcase

        if (fb_index == 5'd0) fb_is_valid = 1'b0;
        // Register 0 is hardwired, which also swallows upper writes that wrap past r31.
        regs_d[0] = '0;
    end

    for (genvar n = 0; n < 32; n++) begin : g_regs
        assign registers[32*n +: 32] = regs_q[n];
    end

    assign bus.in_hold       = (state_q != READY);
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_writedata = mem_writedata_q;
    assign bus.mem_write     = mem_write_q;
    assign retired           = retired_q;
    assign retired_pc        = retired_pc_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: a register-file model and a queue of
// expected retired pcs, compared against the DUT scenario by scenario.
module tb_write_back;
    logic          clock = 1'b0;
    logic          reset;
    logic [1023:0] registers;
    logic          fb_is_valid;
    logic [4:0]    fb_index;
    logic [31:0]   fb_value;
    logic          retired;
    logic [31:0]   retired_pc;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];
    logic [31:0] exp_pc_q [$];

    write_back_if bus();

    write_back #(.FLAGS_INDEX(30)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .registers   (registers),
        .fb_is_valid (fb_is_valid),
        .fb_index    (fb_index),
        .fb_value    (fb_value),
        .retired     (retired),
        .retired_pc  (retired_pc)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] tr, input logic [4:0] ar,
                             input logic st, input logic [3:0] fl, input logic [31:0] tv,
                             input logic [31:0] uv, input logic [31:0] adj, input logic up,
                             input logic fsh);
        bus.in_valid             = 1'b1;
        bus.in_pc                = pc;
        bus.in_target_register   = tr;
        bus.in_address_register  = ar;
        bus.in_is_writing_memory = st;
        bus.in_flags             = fl;
        bus.in_target_value      = tv;
        bus.in_upper_value       = uv;
        bus.in_adjustment_value  = adj;
        bus.in_has_upper_value   = up;
        bus.in_has_flushed       = fsh;
    endtask

    task automatic model_flags(input logic [3:0] fl);
        model[30][30:27] = fl;
    endtask

    task automatic model_write(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 5'd0) model[idx] = v;
    endtask

    function automatic int first_diff();
        for (int n = 0; n < 32; n++)
            if (registers[n*32 +: 32] !== model[n]) return n;
        return -1;
    endfunction

    task automatic test_reset();
        int d;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.mem_waitrequest = 1'b0;
        set_instr(32'h0, 5'd0, 5'd0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        for (int n = 0; n < 32; n++) model[n] = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (bus.in_hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", bus.in_hold); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 0", bus.mem_address); end
        checks++; if (bus.mem_writedata !== 32'h0) begin errors++; $display("FAIL reset_mem_writedata: got %h want 0", bus.mem_writedata); end
        checks++; if (retired !== 1'b0 || retired_pc !== 32'h0) begin errors++; $display("FAIL reset_retired: got %b/%h want 0/0", retired, retired_pc); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL reset_regs: r%0d got %h want %h", d, registers[d*32 +: 32], model[d]); end
    endtask

    task automatic test_simple();
        int d;
        logic [31:0] exp;
        set_instr(32'h100, 5'd30, 5'd0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_pc_q.push_back(32'h100);
        model_flags(4'b0000);
        model_write(5'd30, 32'hFFFF_FFFF);
        #1;
        checks++; if (fb_is_valid !== 1'b1 || fb_index !== 5'd30) begin errors++; $display("FAIL fb_simple: got %b/%0d want 1/30", fb_is_valid, fb_index); end
        tick();
        set_instr(32'h104, 5'd5, 5'd0, 1'b0, 4'b0101, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_pc_q.push_back(32'h104);
        model_flags(4'b0101);
        model_write(5'd5, 32'h1234_5678);
        checks++; if (retired !== 1'b1) begin errors++; $display("FAIL retire_flags_target: got %b want 1", retired); end
        if (exp_pc_q.size() != 0) begin
            exp = exp_pc_q.pop_front();
            checks++; if (retired_pc !== exp) begin errors++; $display("FAIL retire_pc_flags_target: got %h want %h", retired_pc, exp); end
        end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (retired !== 1'b1) begin errors++; $display("FAIL retire_simple: got %b want 1", retired); end
        if (exp_pc_q.size() != 0) begin
            exp = exp_pc_q.pop_front();
            checks++; if (retired_pc !== exp) begin errors++; $display("FAIL retire_pc_simple: got %h want %h", retired_pc, exp); end
        end
        checks++; if (registers[30*32 +: 32] !== 32'hAFFF_FFFF) begin errors++; $display("FAIL flags_merge: got %h want afffffff", registers[30*32 +: 32]); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL regs_simple: r%0d got %h want %h", d, registers[d*32 +: 32], model[d]); end
        tick();
        checks++; if (retired !== 1'b0) begin errors++; $display("FAIL retire_pulse_width: got %b want 0", retired); end
    endtask

    task automatic test_upper();
        int d;
        logic [31:0] exp;
        set_instr(32'h108, 5'd7, 5'd0, 1'b0, 4'b0011, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        exp_pc_q.push_back(32'h108);
        #1;
        checks++; if (fb_is_valid !== 1'b1 || fb_index !== 5'd7 || fb_value !== 32'h1) begin errors++; $display("FAIL fb_low: got %b/%0d/%h want 1/7/1", fb_is_valid, fb_index, fb_value); end
        tick();
        bus.in_valid = 1'b0;
        model_flags(4'b0011);
        model_write(5'd7, 32'h1);
        checks++; if (bus.in_hold !== 1'b1) begin errors++; $display("FAIL upper_hold: got %b want 1", bus.in_hold); end
        checks++; if (fb_is_valid !== 1'b1 || fb_index !== 5'd8 || fb_value !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fb_upper: got %b/%0d/%h want 1/8/ffffffff", fb_is_valid, fb_index, fb_value); end
        checks++; if (retired !== 1'b0) begin errors++; $display("FAIL upper_early_retire: got %b want 0", retired); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL regs_low: r%0d got %h want %h", d, registers[d*32 +: 32], model[d]); end
        tick();
        model_write(5'd8, 32'hFFFF_FFFF);
        checks++; if (bus.in_hold !== 1'b0) begin errors++; $display("FAIL upper_hold_release: got %b want 0", bus.in_hold); end
        checks++; if (retired !== 1'b1) begin errors++; $display("FAIL retire_upper: got %b want 1", retired); end
        if (exp_pc_q.size() != 0) begin
            exp = exp_pc_q.pop_front();
            checks++; if (retired_pc !== exp) begin errors++; $display("FAIL retire_pc_upper: got %h want %h", retired_pc, exp); end
        end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL regs_upper: r%0d got %h want %h", d, registers[d*32 +: 32], model[d]); end
    endtask

    task automatic test_store();
        int d;
        int cnt;
        logic [31:0] exp;
        set_instr(32'h10C, 5'd3, 5'd0, 1'b0, 4'b0000, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b0);
        model_flags(4'b0000);
        model_write(5'd3, 32'h1000);
        tick();
        set_instr(32'h110, 5'd9, 5'd3, 1'b1, 4'b1000, 32'hCAFE, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        bus.mem_waitrequest = 1'b1;
        exp_pc_q.push_back(32'h110);
        #1;
        checks++; if (fb_is_valid !== 1'b0) begin errors++; $display("FAIL fb_store: got %b want 0", fb_is_valid); end
        tick();
        bus.in_valid = 1'b0;
        model_flags(4'b1000);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (bus.mem_write === 1'b1) cnt++;
            checks++; if (bus.in_hold !== bus.mem_write) begin errors++; $display("FAIL store_hold_%0d: hold %b mem_write %b", i, bus.in_hold, bus.mem_write); end
            if (i < 4) begin
                checks++; if (bus.mem_address !== 32'h0000_0FFC || bus.mem_writedata !== 32'hCAFE) begin errors++; $display("FAIL store_bus_%0d: got %h/%h want 00000ffc/0000cafe", i, bus.mem_address, bus.mem_writedata); end
            end
            if (i == 4) begin
                checks++; if (retired !== 1'b1) begin errors++; $display("FAIL retire_store: got %b want 1", retired); end
                if (exp_pc_q.size() != 0) begin
                    exp = exp_pc_q.pop_front();
                    checks++; if (retired_pc !== exp) begin errors++; $display("FAIL retire_pc_store: got %h want %h", retired_pc, exp); end
                end
            end
            if (i == 3) bus.mem_waitrequest = 1'b0;
            tick();
        end
        checks++; if (cnt !== 4) begin errors++; $display("FAIL store_write_cycles: got %0d want 4", cnt); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL regs_store: r%0d got %h want %h", d, registers[d*32 +: 32], model[d]); end
    endtask

    task automatic test_flushed();
        int d;
        set_instr(32'h114, 5'd9, 5'd0, 1'b0, 4'b1111, 32'hDEAD, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        checks++; if (fb_is_valid !== 1'b0) begin errors++; $display("FAIL fb_flushed: got %b want 0", fb_is_valid); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (retired !== 1'b0 || bus.in_hold !== 1'b0) begin errors++; $display("FAIL flushed_retire_hold: got %b/%b want 0/0", retired, bus.in_hold); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL regs_flushed: r%0d got %h want %h", d, registers[d*32 +: 32], model[d]); end
    endtask

    task automatic test_r0_wrap();
        int d;
        logic [31:0] exp;
        set_instr(32'h118, 5'd0, 5'd0, 1'b0, 4'b0001, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_pc_q.push_back(32'h118);
        model_flags(4'b0001);
        #1;
        checks++; if (fb_is_valid !== 1'b0) begin errors++; $display("FAIL fb_r0: got %b want 0", fb_is_valid); end
        tick();
        set_instr(32'h11C, 5'd31, 5'd0, 1'b0, 4'b0110, 32'h31, 32'h77, 32'h0, 1'b1, 1'b0);
        exp_pc_q.push_back(32'h11C);
        if (exp_pc_q.size() != 0) begin
            exp = exp_pc_q.pop_front();
            checks++; if (retired !== 1'b1 || retired_pc !== exp) begin errors++; $display("FAIL retire_r0: got %b/%h want 1/%h", retired, retired_pc, exp); end
        end
        tick();
        bus.in_valid = 1'b0;
        model_flags(4'b0110);
        model_write(5'd31, 32'h31);
        checks++; if (bus.in_hold !== 1'b1 || fb_is_valid !== 1'b0) begin errors++; $display("FAIL wrap_upper_state: hold %b fb %b want 1/0", bus.in_hold, fb_is_valid); end
        tick();
        if (exp_pc_q.size() != 0) begin
            exp = exp_pc_q.pop_front();
            checks++; if (retired !== 1'b1 || retired_pc !== exp) begin errors++; $display("FAIL retire_wrap: got %b/%h want 1/%h", retired, retired_pc, exp); end
        end
        checks++; if (registers[31:0] !== 32'h0) begin errors++; $display("FAIL r0_zero: got %h want 0", registers[31:0]); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL regs_wrap: r%0d got %h want %h", d, registers[d*32 +: 32], model[d]); end
    endtask

    task automatic test_reset_mid_store();
        int d;
        set_instr(32'h120, 5'd4, 5'd5, 1'b1, 4'b0010, 32'hBEEF, 32'h0, 32'h4, 1'b1, 1'b0);
        bus.mem_waitrequest = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h1234_567C) begin errors++; $display("FAIL reset_store_setup: got %b/%h want 1/1234567c", bus.mem_write, bus.mem_address); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem_waitrequest = 1'b0;
        for (int n = 0; n < 32; n++) model[n] = 32'h0;
        exp_pc_q.delete();
        checks++; if (bus.mem_write !== 1'b0 || bus.in_hold !== 1'b0) begin errors++; $display("FAIL reset_mid_store: mem_write %b hold %b want 0/0", bus.mem_write, bus.in_hold); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL regs_after_reset: r%0d got %h want %h", d, registers[d*32 +: 32], model[d]); end
        tick();
        checks++; if (bus.in_hold !== 1'b0 || retired !== 1'b0) begin errors++; $display("FAIL no_pending_upper: hold %b retired %b want 0/0", bus.in_hold, retired); end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_upper();
        test_store();
        test_flushed();
        test_r0_wrap();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
